// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: RV32 opcodes, result-kind enum and the
// in-flight destination tag carried by the bypass controller.
package cpu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BRANCH= 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_ALU  = 2'd1,
    K_LINK = 2'd2,
    K_LOAD = 2'd3
  } kind_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    kind_e      kind;
  } tag_t;

  // Writes to x0 are architecturally invisible, so they never produce a bypass source.
  function automatic kind_e decode_kind(input logic [6:0] opcode, input logic [4:0] rd);
    kind_e k;
    case (opcode)
      OP_LOAD:                      k = K_LOAD;
      OP_JAL, OP_JALR:              k = K_LINK;
      OP_R, OP_IMM, OP_LUI, OP_AUIPC: k = K_ALU;
      default:                      k = K_NONE;
    endcase
    if (rd == 5'd0) k = K_NONE;
    return k;
  endfunction

endpackage

// File: rtl/bypass_ctrl_fwd_port.sv
// One decode read port: youngest-first match over the tag pipeline, falling
// back to the retire buffer and then the register file value.
module fwd_port
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_STG = 1
) (
  input  tag_t [DEPTH-1:0]       tags_i,
  input  logic [DEPTH*XLEN-1:0]  stg_alu_i,
  input  logic [DEPTH*XLEN-1:0]  stg_link_i,
  input  logic [DEPTH*XLEN-1:0]  stg_ld_i,
  input  logic                   ret_valid_i,
  input  logic [4:0]             ret_rd_i,
  input  logic [XLEN-1:0]        ret_val_i,
  input  logic [4:0]             rs_i,
  input  logic [XLEN-1:0]        rval_i,
  output logic [XLEN-1:0]        fwd_val_o,
  output logic                   hazard_o
);

  // Scan oldest to youngest so the youngest match overwrites any older one;
  // the hazard bit therefore reflects only the winning match.
  always_comb begin
    fwd_val_o = rval_i;
    hazard_o  = 1'b0;
    if (rs_i != 5'd0) begin
      if (ret_valid_i && (ret_rd_i == rs_i)) fwd_val_o = ret_val_i;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (tags_i[s].valid && (tags_i[s].kind != K_NONE) && (tags_i[s].rd == rs_i)) begin
          hazard_o = 1'b0;
          case (tags_i[s].kind)
            K_LINK: fwd_val_o = stg_link_i[s*XLEN +: XLEN];
            K_LOAD: begin
              fwd_val_o = stg_ld_i[s*XLEN +: XLEN];
              hazard_o  = (s < LOAD_STG);
            end
            default: fwd_val_o = stg_alu_i[s*XLEN +: XLEN];
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/bypass_ctrl.sv
// Forwarding and load-use hazard controller. Define BYPASS_RETIRE_EN to add a
// one-entry retire buffer for register files that write at the end of W.
module bypass_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NRP      = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_STG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic [6:0]            issue_opcode,
  input  logic [DEPTH*XLEN-1:0] stg_alu,
  input  logic [DEPTH*XLEN-1:0] stg_link,
  input  logic [DEPTH*XLEN-1:0] stg_ld,
  input  logic [NRP*5-1:0]      rs,
  input  logic [NRP*XLEN-1:0]   rval,
  output logic [NRP*XLEN-1:0]   fwd_val,
  output logic                  stall,
  output logic [15:0]           hz_cnt
);

  tag_t [DEPTH-1:0] tags_q, tags_d;
  tag_t             issue_tag;
  logic [NRP-1:0]   hazard;
  logic [15:0]      hz_cnt_q, hz_cnt_d;
  logic             ret_valid;
  logic [4:0]       ret_rd;
  logic [XLEN-1:0]  ret_val;

  assign stall  = |hazard;
  assign hz_cnt = hz_cnt_q;

  // A stalled or flushed issue enters E as a bubble.
  always_comb begin
    issue_tag.valid = issue_valid & ~flush & ~stall;
    issue_tag.rd    = issue_rd;
    issue_tag.kind  = decode_kind(issue_opcode, issue_rd);
  end

  always_comb begin
    tags_d = tags_q;
    if (adv) begin
      tags_d[0] = issue_tag;
      for (int s = 1; s < DEPTH; s++) tags_d[s] = tags_q[s-1];
    end
  end

  always_comb begin
    hz_cnt_d = hz_cnt_q;
    if (stall && (hz_cnt_q != 16'hFFFF)) hz_cnt_d = hz_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q   <= '0;
      hz_cnt_q <= '0;
    end else begin
      tags_q   <= tags_d;
      hz_cnt_q <= hz_cnt_d;
    end
  end

`ifdef BYPASS_RETIRE_EN
  logic            ret_valid_q, ret_valid_d;
  logic [4:0]      ret_rd_q, ret_rd_d;
  logic [XLEN-1:0] ret_val_q, ret_val_d;

  // Capture the W-stage result as it leaves; a retiring bubble or non-writer clears it.
  always_comb begin
    ret_valid_d = ret_valid_q;
    ret_rd_d    = ret_rd_q;
    ret_val_d   = ret_val_q;
    if (adv) begin
      ret_valid_d = tags_q[DEPTH-1].valid && (tags_q[DEPTH-1].kind != K_NONE);
      ret_rd_d    = tags_q[DEPTH-1].rd;
      case (tags_q[DEPTH-1].kind)
        K_LINK:  ret_val_d = stg_link[(DEPTH-1)*XLEN +: XLEN];
        K_LOAD:  ret_val_d = stg_ld[(DEPTH-1)*XLEN +: XLEN];
        default: ret_val_d = stg_alu[(DEPTH-1)*XLEN +: XLEN];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_q <= 1'b0;
      ret_rd_q    <= '0;
      ret_val_q   <= '0;
    end else begin
      ret_valid_q <= ret_valid_d;
      ret_rd_q    <= ret_rd_d;
      ret_val_q   <= ret_val_d;
    end
  end

  assign ret_valid = ret_valid_q;
  assign ret_rd    = ret_rd_q;
  assign ret_val   = ret_val_q;
`else
  assign ret_valid = 1'b0;
  assign ret_rd    = '0;
  assign ret_val   = '0;
`endif

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_port #(
      .XLEN    (XLEN),
      .DEPTH   (DEPTH),
      .LOAD_STG(LOAD_STG)
    ) u_port (
      .tags_i     (tags_q),
      .stg_alu_i  (stg_alu),
      .stg_link_i (stg_link),
      .stg_ld_i   (stg_ld),
      .ret_valid_i(ret_valid),
      .ret_rd_i   (ret_rd),
      .ret_val_i  (ret_val),
      .rs_i       (rs[p*5 +: 5]),
      .rval_i     (rval[p*XLEN +: XLEN]),
      .fwd_val_o  (fwd_val[p*XLEN +: XLEN]),
      .hazard_o   (hazard[p])
    );
  end

endmodule

// File: doc/bypass_ctrl.md
# bypass_ctrl

Parametrised forwarding and load-use hazard controller for the RISC-V integer pipeline. It tracks its own shift-register of in-flight destination tags (rd, result kind) across DEPTH post-decode stages, so the pipeline supplies only the issuing instruction's rd/opcode and per-stage result buses. It serves NRP decode read ports with youngest-first bypassing, raises a load-use stall, and optionally holds the last retired write for one extra cycle. It sits between decode and the execute/memory/writeback stages, next to the register file.

## Interface
- XLEN, 32: datapath width.
- NRP, 2: number of register read ports served.
- DEPTH, 3: post-decode stages tracked; stage 0 = E, DEPTH-1 = W.
- LOAD_STG, 1: first stage index where load data is valid (1 = M).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- adv  in  1  pipeline advances this cycle; tags shift only when high.
- flush  in  1  squash the instruction issuing from decode this cycle.
- issue_valid  in  1  decode holds a valid instruction.
- issue_rd  in  5  its destination register.
- issue_opcode  in  7  its opcode.
- stg_alu  in  DEPTH*XLEN  per-stage ALU result (valE).
- stg_link  in  DEPTH*XLEN  per-stage link value (default_pc).
- stg_ld  in  DEPTH*XLEN  per-stage load data; slices below LOAD_STG are ignored.
- rs  in  NRP*5  source register per read port.
- rval  in  NRP*XLEN  register-file read value per port.
- fwd_val  out  NRP*XLEN  forwarded operand per port.
- stall  out  1  load-use hazard; decode must hold.
- hz_cnt  out  16  saturating count of stall cycles.

## Operation
- Kind decode of issue_opcode:
  - LOAD → K_LOAD.
  - JAL or JALR → K_LINK.
  - R, IMM, LUI or AUIPC → K_ALU.
  - Anything else, or rd == 0 → K_NONE.
- Tag pipeline: DEPTH entries {valid, rd, kind}. On adv:
  - Entry 0 is loaded with the issuing instruction's tag when issue_valid & ~flush & ~stall; otherwise it receives a bubble (valid = 0).
  - Entry s takes entry s-1.
  - The old entry DEPTH-1 retires.
- Per port, match against stages 0..DEPTH-1 in that order; the youngest match wins. A match requires valid, kind != K_NONE, rd == rs and rs != 0.
- Selected value by kind:
  - K_LINK → stg_link[s].
  - K_ALU → stg_alu[s].
  - K_LOAD → stg_ld[s] when s ≥ LOAD_STG.
- No match → rval. rs == 0 always gives rval.
- stall = 1 when any port's winning match is K_LOAD at stage s < LOAD_STG. fwd_val on that port is don't-care while stall is high.
- hz_cnt increments on each clk where stall = 1 and saturates at 16'hFFFF.

## Timing
- fwd_val and stall are combinational from tags and inputs: zero latency, same cycle.
- Tags update on the rising edge only when adv = 1; with adv = 0 all tags hold.
- Load-use case: load in E, dependent in decode. stall is high for exactly (LOAD_STG) adv cycles. With the defaults this is 1 bubble, after which the value comes from stg_ld[M].
- flush and stall together: a bubble is inserted.
- Reset values:
  - All tag entries invalid.
  - Retire buffer invalid.
  - hz_cnt = 0.
  - Consequently stall = 0 and fwd_val = rval.
- Reset asserted mid-operation clears all state immediately, asynchronously.

## Configuration
- BYPASS_RETIRE_EN defined:
  - A one-entry retire buffer captures {rd, value} of entry DEPTH-1 on adv when it is valid and writing.
  - The buffer is matched last, at lowest priority, after stage DEPTH-1.
  - It is invalidated by the next adv that retires a bubble or non-writer.
  - Purpose: covers a register file that writes at the end of W.
- Undefined: no buffer; the register file must provide write-before-read.

## Structure
- Shared package cpu_pkg holds:
  - OP_* opcode constants.
  - Kind enum {K_NONE, K_ALU, K_LINK, K_LOAD}.
  - Tag struct {valid, rd, kind}.
- Sub-module fwd_port: one read port's priority match/mux plus its hazard bit. Instantiated NRP times via generate.
- The top level holds the tag pipeline, retire buffer, stall OR-reduction and hz_cnt.

## Test plan
- Reset with rs=5, rval=32'h11 → fwd_val=32'h11, stall=0, hz_cnt=0.
- ADDI x5 issued, one adv, stg_alu[E]=32'hA5, rs0=5 → fwd_val0=32'hA5. Then an older x5 writer in M with 32'h77 also present → still 32'hA5 (youngest wins).
- LOAD x7 issued, adv, rs1=7 → stall=1 for one cycle, bubble inserted. Next adv with stg_ld[M]=32'hDEAD → fwd_val1=32'hDEAD, stall=0, hz_cnt=1.
- JAL x1 in M, stg_link[M]=32'h104 → rs=1 gets 32'h104. Writer to x0 in E with rs=0 → rval.
- flush on the issue of ADDI x9, then adv → x9 is never forwarded in any stage.
- With BYPASS_RETIRE_EN: ADDI x3 retires from W with 32'h3C; next cycle rs=3, rval=32'h0 → fwd_val=32'h3C. Without the macro → 32'h0.
